// File: rtl/mips_lsu_pkg.sv
// Shared types, constants and helpers for the MIPS load/store unit.
package mips_lsu_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned DATA_W = LANES * LANE_W;

    // Big-endian lane vector: lane 0 occupies bits [31:24].
    typedef logic [0:LANES-1][LANE_W-1:0] lanes_t;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WRITE   = 3'd2,
        WR_WAIT = 3'd3,
        RESP    = 3'd4
    } lsu_state_e;

    // Request fields captured at accept and held for the whole access.
    typedef struct packed {
        logic              write;
        lsu_size_e         size;
        logic              sign;
        logic [1:0]        offs;
        logic [DATA_W-1:0] wdata;
    } lsu_req_t;

    // Misaligned halfword/word or the reserved size encoding.
    function automatic logic misaligned(input lsu_size_e size, input logic [1:0] offs);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = offs[0];
            SZ_W:    bad = (offs != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// Core-side request/response handshake plus byte-lane memory bus.
interface mips_lsu_if #(
    parameter int unsigned ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_W-1:0]     req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_error;
    logic [ADDR_W-1:0]     mem_addr;
    mips_lsu_pkg::lanes_t  mem_data_out;
    mips_lsu_pkg::lanes_t  mem_data_in;
    logic                  mem_write_en;

    // LSU view.
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_data_in, mem_write_en
    );

    // Core and memory view.
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_data_in, mem_write_en
    );
endinterface

// File: rtl/mips_lsu_align.sv
// Combinational lane steering: load extract/extend and sub-word store merge.
module mips_lsu_align
    import mips_lsu_pkg::*;
(
    input  lsu_size_e   size_i,
    input  logic        sign_i,
    input  logic [1:0]  offs_i,
    input  lanes_t      rd_lanes_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output lanes_t      st_lanes_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed lane(s) and extend to 32 bits.
    always_comb begin
        byte_v    = rd_lanes_i[offs_i];
        half_v    = offs_i[1] ? {rd_lanes_i[2], rd_lanes_i[3]} : {rd_lanes_i[0], rd_lanes_i[1]};
        ld_data_o = '0;
        case (size_i)
            SZ_B:    ld_data_o = sign_i ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
            SZ_H:    ld_data_o = sign_i ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
            default: ld_data_o = 32'(rd_lanes_i);
        endcase
    end

    // Overwrite only the target lane(s) of the word just read.
    always_comb begin
        st_lanes_o = rd_lanes_i;
        case (size_i)
            SZ_B: st_lanes_o[offs_i] = wdata_i[7:0];
            SZ_H: begin
                if (offs_i[1]) begin
                    st_lanes_o[2] = wdata_i[15:8];
                    st_lanes_o[3] = wdata_i[7:0];
                end else begin
                    st_lanes_o[0] = wdata_i[15:8];
                    st_lanes_o[1] = wdata_i[7:0];
                end
            end
            default: st_lanes_o = lanes_t'(wdata_i);
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit: one access in flight, configurable memory latency, RMW for sub-word stores.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic      clk,
    input  logic      rst_b,
    mips_lsu_if.slave bus
);

    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    lsu_req_t          req_q, req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    lanes_t            mem_data_in_q, mem_data_in_d;
    logic              mem_write_en_q, mem_write_en_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_error_q, resp_error_d;

    lsu_size_e         acc_size;
    logic [31:0]       ld_data;
    lanes_t            st_lanes;

    assign acc_size = lsu_size_e'(bus.req_size);

    mips_lsu_align u_align (
        .size_i     (req_q.size),
        .sign_i     (req_q.sign),
        .offs_i     (req_q.offs),
        .rd_lanes_i (bus.mem_data_out),
        .wdata_i    (req_q.wdata),
        .ld_data_o  (ld_data),
        .st_lanes_o (st_lanes)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        mem_addr_d     = mem_addr_q;
        mem_data_in_d  = mem_data_in_q;
        mem_write_en_d = 1'b0;
        resp_valid_d   = 1'b0;
        resp_rdata_d   = '0;
        resp_error_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_d      = '{write: bus.req_write, size: acc_size, sign: bus.req_signed,
                                   offs: bus.req_addr[1:0], wdata: bus.req_wdata};
                    mem_addr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    if (misaligned(acc_size, bus.req_addr[1:0])) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (bus.req_write && acc_size == SZ_W) begin
                        state_d        = WRITE;
                        mem_write_en_d = 1'b1;
                        mem_data_in_d  = lanes_t'(bus.req_wdata);
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    if (req_q.write) begin
                        state_d        = WRITE;
                        mem_write_en_d = 1'b1;
                        mem_data_in_d  = st_lanes;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = ld_data;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WRITE: begin
                state_d = WR_WAIT;
                cnt_d   = CNT_LOAD;
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            req_q          <= '0;
            mem_addr_q     <= '0;
            mem_data_in_q  <= '0;
            mem_write_en_q <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_in_q  <= mem_data_in_d;
            mem_write_en_q <= mem_write_en_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_error_q   <= resp_error_d;
        end
    end

    assign bus.req_ready    = (state_q == IDLE);
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_data_in  = mem_data_in_q;
    assign bus.mem_write_en = mem_write_en_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.resp_error   = resp_error_q;

endmodule
